instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Parametrised instruction memory with a built-in clear engine and a streaming load port. It gives the single-cycle core a combinational, byte-addressed fetch port with alignment and range checking. A valid/ready loader fills program words at runtime. The block replaces the fixed-size, reset-filled instruction store in the fetch stage. The debug/boot host drives the load port.

## Interface
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, byte-address width of `pc`, `ld_base`
- DEPTH, 64, number of words (≥2); word index width IDX_W = $clog2(DEPTH)
- FILL_VALUE, 32'h00000013, word written to every location by the clear engine (RV32 NOP)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset: asynchronous, active-high
- en  in  1  fetch enable
- pc  in  ADDR_WIDTH  fetch byte address
- instr  out  DATA_WIDTH  fetched word, 0 when not valid
- instr_valid  out  1  `instr` is valid this cycle
- fetch_fault  out  1  misaligned or out-of-range fetch
- busy  out  1  clear or load in progress
- ld_start  in  1  one-cycle request to begin a load
- ld_base  in  ADDR_WIDTH  word index of first load word
- ld_valid  in  1  load beat valid
- ld_data  in  DATA_WIDTH  load beat data
- ld_last  in  1  final beat of burst
- ld_ready  out  1  load beat accepted when high with `ld_valid`
- ld_err  out  1  sticky load error, cleared by next accepted `ld_start`
- ld_count  out  IDX_W+1  beats written in current/last burst

## Operation
- FSM states: CLEAR, IDLE, LOAD.
- Reset (async) forces CLEAR, cptr=0, ld_err=0, ld_count=0.
- Reset outputs: busy=1, ld_ready=0, instr=0, instr_valid=0, fetch_fault=0.
- CLEAR:
  - Each cycle: mem[cptr]<=FILL_VALUE, cptr++.
  - At cptr==DEPTH-1, write, then go to IDLE.
  - `ld_start` ignored.
- IDLE: `ld_start`=1 →
  - If ld_base<DEPTH: wptr=ld_base, ld_count=0, ld_err=0, go to LOAD.
  - Otherwise: ld_err=1, stay IDLE.
- LOAD:
  - ld_ready=1.
  - Beat (ld_valid&ld_ready): mem[wptr]<=ld_data, wptr++, ld_count++.
  - Beat with ld_last → IDLE.
  - Beat at wptr==DEPTH-1 without ld_last → write it, set ld_err, go to IDLE (no wrap).
  - `ld_start` ignored.
- Fetch (combinational): word = pc>>2.
  - instr_valid = en & state==IDLE & pc[1:0]==0 & word<DEPTH.
  - instr = instr_valid ? mem[word] : 0.
  - fetch_fault = en & state==IDLE & (pc[1:0]!=0 | word<DEPTH false).
- busy = state!=IDLE.

## Timing
- CLEAR lasts exactly DEPTH cycles after rst deassertion; busy falls on the edge after the last fill write.
- Fetch latency 0 cycles (combinational read); writes land on the rising edge.
- A loaded word is fetchable in the first cycle after its write edge, once state==IDLE.
- ld_ready is registered state only (no combinational path from ld_valid); it rises the cycle after an accepted ld_start.
- On a final or overflow beat, ld_ready drops the next cycle; later beats are not accepted.
- ld_start in the same cycle CLEAR completes is ignored.
- rst mid-LOAD: ld_ready drops immediately and memory is fully re-cleared.

## Structure
- Package `instr_mem_pkg`:
  - state enum (ST_CLEAR, ST_IDLE, ST_LOAD)
  - NOP constant 32'h00000013
- Sub-module `instr_mem_array`: DEPTH×DATA_WIDTH storage, one synchronous write port, one combinational read port.
- FSM, pointers and checks live in the top.

## Test plan (DEPTH=8)
- Reset release → busy=1 for 8 cycles, then 0. Then en=1, pc=0x1C → instr=0x00000013, instr_valid=1.
- Load burst:
  - Stimulus: ld_start, ld_base=2; beats 0xAAAA0001, 0xAAAA0002, 0xAAAA0003 with one idle cycle between; ld_last on the third.
  - Response: pc=0x08 → 0xAAAA0001, pc=0x10 → 0xAAAA0003, pc=0x04 → 0x00000013, ld_count=3, ld_err=0.
- Fetch checks:
  - pc=0x06 → fetch_fault=1, instr=0, instr_valid=0.
  - pc=0x20 → fetch_fault=1.
  - en=0 → fault=0, valid=0.
- Overflow: ld_base=6, three beats without ld_last → words 6,7 written, third beat sees ld_ready=0, ld_err=1, ld_count=2. ld_start ld_base=9 → ld_err=1, state stays IDLE.
- Fetch during LOAD → instr_valid=0, instr=0. After ld_last → fetch resumes the next cycle.
- Reset mid-load:
  - Stimulus: assert rst after one beat written at word 3.
  - Response: ld_ready=0 at once, busy=1; after 8 clear cycles, word 3 reads 0x00000013.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory loader.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_LOAD
  } state_e;

  localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/instr_mem_array.sv
// Word storage: one synchronous write port, one combinational read port.
module instr_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with clear engine, streaming loader and checked fetch.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = NOP,
  localparam int                   IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic                  fetch_fault,
  output logic                  busy,
  input  logic                  ld_start,
  input  logic [ADDR_WIDTH-1:0] ld_base,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  ld_err,
  output logic [IDX_W:0]        ld_count
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      cptr_q, cptr_d;
  logic [IDX_W-1:0]      wptr_q, wptr_d;
  logic                  err_q, err_d;
  logic [IDX_W:0]        cnt_q, cnt_d;

  logic                  we;
  logic [IDX_W-1:0]      waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] word;
  logic                  aligned, in_rng, idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cptr_q  <= '0;
      wptr_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cptr_q  <= cptr_d;
      wptr_q  <= wptr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cptr_d  = cptr_q;
    wptr_d  = wptr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    waddr   = cptr_q;
    wdata   = FILL_VALUE;
    unique case (state_q)
      ST_CLEAR: begin
        we = 1'b1;
        if (cptr_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cptr_d  = '0;
        end else begin
          cptr_d = cptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (ld_start) begin
          if (ld_base < DEPTH_A) begin
            wptr_d  = ld_base[IDX_W-1:0];
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          we    = 1'b1;
          waddr = wptr_q;
          wdata = ld_data;
          cnt_d = cnt_q + 1'b1;
          if (ld_last) begin
            state_d = ST_IDLE;
          end else if (wptr_q == LAST_IDX) begin
            // No wrap: the top word is written, then the burst is cut off
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wptr_d = wptr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  instr_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(word[IDX_W-1:0]),
    .rdata(rdata)
  );

  assign word        = {2'b00, pc[ADDR_WIDTH-1:2]};
  assign aligned     = (pc[1:0] == 2'b00);
  assign in_rng      = (word < DEPTH_A);
  assign idle        = (state_q == ST_IDLE);
  assign instr_valid = en & idle & aligned & in_rng;
  assign fetch_fault = en & idle & (~aligned | ~in_rng);
  assign instr       = instr_valid ? rdata : '0;
  assign busy        = ~idle;
  assign ld_ready    = (state_q == ST_LOAD);
  assign ld_err      = err_q;
  assign ld_count    = cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader against a transaction-level model.
module tb_instr_mem_loader;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 8;
  localparam logic [31:0] NOPV = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [AW-1:0] pc;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          fetch_fault;
  logic          busy;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_err;
  logic [3:0]    ld_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_m [DEPTH];
  bit          err_m;
  int          cnt_m;

  always #5 clk = ~clk;

  instr_mem_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pc         (pc),
    .instr      (instr),
    .instr_valid(instr_valid),
    .fetch_fault(fetch_fault),
    .busy       (busy),
    .ld_start   (ld_start),
    .ld_base    (ld_base),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_err     (ld_err),
    .ld_count   (ld_count)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input logic [31:0] a, input bit e);
    int  w;
    bit  al, inr, v;
    en = e;
    pc = a;
    #1;
    w   = int'(a >> 2);
    al  = (a[1:0] == 2'b00);
    inr = (a >> 2) < DEPTH;
    v   = e && al && inr;
    check("instr_valid", {31'b0, instr_valid}, {31'b0, v});
    check("fetch_fault", {31'b0, fetch_fault}, {31'b0, e && !(al && inr)});
    check("instr", instr, v ? mem_m[w] : 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b1;
    pc = '0;
    ld_start = 1'b0;
    ld_base = '0;
    ld_valid = 1'b0;
    ld_data = '0;
    ld_last = 1'b0;
    #2;
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_ready", {31'b0, ld_ready}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
    check("rst_err", {31'b0, ld_err}, 32'd0);
    check("rst_count", {28'b0, ld_count}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = NOPV;
    err_m = 0;
    cnt_m = 0;
    for (int i = 0; i < DEPTH; i++) begin
      check("clear_busy", {31'b0, busy}, 32'd1);
      if (i == DEPTH - 1) ld_start = 1'b1;
      step();
      ld_start = 1'b0;
    end
    check("clear_done", {31'b0, busy}, 32'd0);
    check("clear_start_ign", {31'b0, ld_ready}, 32'd0);
  endtask

  // dbase==0 selects random beat data, otherwise dbase+i
  task automatic burst(input int base, input int n, input bit has_last,
                       input int gmin, input int gmax,
                       input logic [31:0] dbase);
    int cap, lastpos, acc, gap;
    bit err;
    logic [31:0] d;
    check("pre_busy", {31'b0, busy}, 32'd0);
    ld_start = 1'b1;
    ld_base = AW'(base);
    step();
    ld_start = 1'b0;
    if (base >= DEPTH) begin
      err_m = 1;
      check("bad_base_err", {31'b0, ld_err}, {31'b0, err_m});
      check("bad_base_busy", {31'b0, busy}, 32'd0);
      check("bad_base_count", {28'b0, ld_count}, cnt_m);
      return;
    end
    cap = DEPTH - base;
    lastpos = has_last ? n - 1 : n;
    acc = (lastpos < cap) ? lastpos + 1 : cap;
    err = !(has_last && lastpos < cap);
    check("start_ready", {31'b0, ld_ready}, 32'd1);
    check("start_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(gmax, gmin);
      repeat (gap) begin
        ld_valid = 1'b0;
        if (i < acc) begin
          ld_start = 1'($urandom);
          ld_base = AW'($urandom_range(DEPTH - 1, 0));
          en = 1'b1;
          pc = AW'($urandom_range(DEPTH * 4 - 1, 0));
          #1;
          check("load_fetch_v", {31'b0, instr_valid}, 32'd0);
          check("load_fetch_i", instr, 32'd0);
          check("load_fetch_f", {31'b0, fetch_fault}, 32'd0);
        end
        step();
        ld_start = 1'b0;
      end
      d = (dbase == 0) ? $urandom : dbase + 32'(i);
      ld_valid = 1'b1;
      ld_data = d;
      ld_last = has_last && (i == n - 1);
      #1;
      check("beat_ready", {31'b0, ld_ready}, {31'b0, i < acc});
      if (i < acc) mem_m[base + i] = d;
      step();
    end
    ld_valid = 1'b0;
    ld_last = 1'b0;
    cnt_m = acc;
    err_m = err;
    check("end_ready", {31'b0, ld_ready}, 32'd0);
    check("end_busy", {31'b0, busy}, 32'd0);
    check("end_count", {28'b0, ld_count}, cnt_m);
    check("end_err", {31'b0, ld_err}, {31'b0, err_m});
    fetch_chk(32'(base * 4), 1'b1);
  endtask

  task automatic sweep();
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(2, 0) == 0) fetch_chk($urandom, ($urandom_range(3, 0) != 0));
      else fetch_chk($urandom_range(DEPTH * 4 + 7, 0), ($urandom_range(3, 0) != 0));
    end
    for (int w = 0; w < DEPTH; w++) fetch_chk(32'(w * 4), 1'b1);
  endtask

  initial begin
    int base, n, cap;
    bit hl;
    do_reset();
    fetch_chk(32'h1C, 1'b1);
    check("nop_top", instr, NOPV);

    burst(2, 3, 1'b1, 1, 1, 32'hAAAA0001);
    fetch_chk(32'h08, 1'b1);
    check("w2", instr, 32'hAAAA0001);
    fetch_chk(32'h10, 1'b1);
    check("w4", instr, 32'hAAAA0003);
    fetch_chk(32'h04, 1'b1);
    check("w1", instr, NOPV);
    check("cnt3", {28'b0, ld_count}, 32'd3);
    fetch_chk(32'h06, 1'b1);
    check("mis_fault", {31'b0, fetch_fault}, 32'd1);
    fetch_chk(32'h20, 1'b1);
    check("oor_fault", {31'b0, fetch_fault}, 32'd1);
    fetch_chk(32'h08, 1'b0);

    burst(6, 3, 1'b0, 0, 1, 32'hBBBB0000);
    check("ovf_err", {31'b0, ld_err}, 32'd1);
    check("ovf_cnt", {28'b0, ld_count}, 32'd2);
    burst(9, 1, 1'b1, 0, 0, 32'h0);
    check("base9_err", {31'b0, ld_err}, 32'd1);
    sweep();

    repeat (14) begin
      base = $urandom_range(DEPTH + 2, 0);
      hl = 1'($urandom);
      n = $urandom_range(5, 1);
      if (!hl && base < DEPTH) begin
        cap = DEPTH - base;
        n = cap + $urandom_range(2, 0);
      end
      burst(base, n, hl, 0, 2, 32'h0);
      sweep();
    end

    ld_start = 1'b1;
    ld_base = 32'd3;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data = 32'hDEAD0003;
    step();
    ld_valid = 1'b0;
    check("mid_ready_pre", {31'b0, ld_ready}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'b0, ld_ready}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd1);
    do_reset();
    fetch_chk(32'h0C, 1'b1);
    check("w3_cleared", instr, NOPV);
    sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
